// File: rtl/lcd_seq_ctrl_pkg.sv
// Shared encodings for the LCD sequencer: main/strobe states, HD44780 init command
// selects and datapath character-source codes.
package lcd_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_ADDR,
    S_NUM,
    S_OP,
    S_GAP
  } main_st_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_PULSE,
    PH_HOLD
  } strobe_ph_e;

  localparam logic [1:0] INIT_FSET   = 2'd3;
  localparam logic [1:0] INIT_ENTRY  = 2'd2;
  localparam logic [1:0] INIT_DISPON = 2'd1;
  localparam logic [1:0] INIT_CLEAR  = 2'd0;

  localparam logic [1:0] DP_NUM = 2'd0;
  localparam logic [1:0] DP_OP  = 2'd1;

  localparam logic [1:0] IDX_LEFT = 2'd3;

endpackage

// File: rtl/lcd_strobe.sv
// SETUP/PULSE/HOLD timer for one LCD bus transfer. The idle cycle in which go is seen
// is the first setup cycle; done is high during the last hold cycle.
module lcd_strobe
  import lcd_seq_ctrl_pkg::*;
#(
  parameter int T_SETUP  = 2,
  parameter int T_EPULSE = 12,
  parameter int T_CMD    = 2000,
  parameter int T_CLEAR  = 82000,
  parameter int CNT_W    = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic long_hold,
  output logic e,
  output logic done
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(T_EPULSE - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(T_CLEAR - 1);

  strobe_ph_e       ph;
  logic [CNT_W-1:0] cnt;
  logic             long_q;
  logic [CNT_W-1:0] hold_last;

  assign hold_last = long_q ? CLEAR_LAST : CMD_LAST;
  // Early done lets the main FSM present the next selects right after the hold.
  assign done      = (ph == PH_HOLD) && (cnt == hold_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph     <= PH_IDLE;
      cnt    <= '0;
      long_q <= 1'b0;
      e      <= 1'b0;
    end else begin
      case (ph)
        PH_IDLE: begin
          if (go) begin
            long_q <= long_hold;
            if (T_SETUP <= 1) begin
              ph  <= PH_PULSE;
              e   <= 1'b1;
              cnt <= '0;
            end else begin
              ph  <= PH_SETUP;
              cnt <= CNT_W'(1);
            end
          end
        end
        PH_SETUP: begin
          if (cnt == SETUP_LAST) begin
            ph  <= PH_PULSE;
            e   <= 1'b1;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PH_PULSE: begin
          if (cnt == PULSE_LAST) begin
            ph  <= PH_HOLD;
            e   <= 1'b0;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PH_HOLD: begin
          if (done) begin
            ph  <= PH_IDLE;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ph <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_seq_ctrl.sv
// HD44780 sequencer: power-up wait, four-command init, then an endless refresh loop of
// cursor address, four operand digits, four mnemonic characters and an idle gap.
module lcd_seq_ctrl
  import lcd_seq_ctrl_pkg::*;
#(
  parameter int T_PWRUP      = 750000,
  parameter int T_SETUP      = 2,
  parameter int T_EPULSE     = 12,
  parameter int T_CMD        = 2000,
  parameter int T_CLEAR      = 82000,
  parameter int T_GAP        = 500000,
  parameter int BLINK_FRAMES = 25,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] init_sel,
  output logic       data_sel,
  output logic       DB_sel,
  output logic [1:0] state,
  output logic [1:0] index,
  output logic       blink,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       init_done
);

  localparam int FRAME_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [CNT_W-1:0]   PWRUP_LAST = CNT_W'(T_PWRUP - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(T_GAP - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  main_st_e           st;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic               go;
  logic               long_hold;
  logic               done;

  assign lcd_rw = 1'b0;

  lcd_strobe #(
    .T_SETUP  (T_SETUP),
    .T_EPULSE (T_EPULSE),
    .T_CMD    (T_CMD),
    .T_CLEAR  (T_CLEAR),
    .CNT_W    (CNT_W)
  ) u_strobe (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .long_hold (long_hold),
    .e         (lcd_e),
    .done      (done)
  );

  // Selects are updated together with go, so they are valid from the first setup cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_PWRUP;
      cnt       <= '0;
      frame_cnt <= '0;
      go        <= 1'b0;
      long_hold <= 1'b0;
      init_sel  <= INIT_FSET;
      data_sel  <= 1'b0;
      DB_sel    <= 1'b1;
      state     <= DP_NUM;
      index     <= IDX_LEFT;
      blink     <= 1'b0;
      lcd_rs    <= 1'b0;
      init_done <= 1'b0;
    end else begin
      go <= 1'b0;
      case (st)
        S_PWRUP: begin
          if (cnt == PWRUP_LAST) begin
            cnt       <= '0;
            st        <= S_INIT;
            init_sel  <= INIT_FSET;
            long_hold <= 1'b0;
            go        <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_INIT: begin
          if (done) begin
            go <= 1'b1;
            if (init_sel == INIT_CLEAR) begin
              st        <= S_ADDR;
              init_done <= 1'b1;
              data_sel  <= 1'b1;
              DB_sel    <= 1'b0;
              long_hold <= 1'b0;
            end else begin
              init_sel  <= init_sel - 2'd1;
              long_hold <= (init_sel == INIT_DISPON);
            end
          end
        end
        S_ADDR: begin
          if (done) begin
            st     <= S_NUM;
            DB_sel <= 1'b1;
            state  <= DP_NUM;
            index  <= IDX_LEFT;
            lcd_rs <= 1'b1;
            go     <= 1'b1;
          end
        end
        S_NUM: begin
          if (done) begin
            go <= 1'b1;
            if (index == 2'd0) begin
              st    <= S_OP;
              state <= DP_OP;
              index <= IDX_LEFT;
            end else begin
              index <= index - 2'd1;
            end
          end
        end
        S_OP: begin
          if (done) begin
            if (index == 2'd0) begin
              st     <= S_GAP;
              cnt    <= '0;
              lcd_rs <= 1'b0;
              state  <= DP_NUM;
              index  <= IDX_LEFT;
              // Blink only moves at the frame boundary so a frame never mixes phases.
              if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                blink     <= ~blink;
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end else begin
              index <= index - 2'd1;
              go    <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt       <= '0;
            st        <= S_ADDR;
            data_sel  <= 1'b1;
            DB_sel    <= 1'b0;
            long_hold <= 1'b0;
            go        <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= S_PWRUP;
      endcase
    end
  end

endmodule
